uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 22 ++
 rtl/uart_tx_fifo.sv | 152 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of the UART transmitter: byte strobe in, FIFO status out.
// DEPTH_LOG2 must match the DEPTH_LOG2 of the uart_tx_fifo it connects to.
interface uart_tx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  wr_en;
  logic [7:0]            wr_data;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;

  modport master (
    output wr_en, wr_data,
    input  full, empty, level, overflow
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, level, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART serializer; frames run back-to-back while
// bytes are queued, and dropped writes raise a sticky overflow flag.
module uart_tx_fifo #(
  parameter int CLOCK_RATE = 24_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  wr,
  output logic           busy,
  output logic           tx
);

  localparam int DIV   = CLOCK_RATE / BAUD_RATE;
  localparam int CW    = $clog2(DIV) + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;

  state_t                state, state_next;
  logic [CW-1:0]         baud_cnt, baud_next;
  logic [2:0]            bit_idx, bit_next;
  logic [7:0]            shift, shift_next;
  logic                  tx_next;
  logic                  pop;
  logic                  baud_done;
  logic                  empty, full, wr_accept;

  assign empty     = (count == '0);
  assign full      = count[DEPTH_LOG2];
  assign wr_accept = wr.wr_en && (!full || pop);
  assign baud_done = (baud_cnt == '0);

  assign wr.empty    = empty;
  assign wr.full     = full;
  assign wr.level    = count;
  assign wr.overflow = overflow;
  assign busy        = (state != IDLE);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    tx_next    = tx;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          baud_next  = RELOAD;
          bit_next   = '0;
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_next  = RELOAD;
          bit_next   = '0;
          tx_next    = shift[0];
          state_next = DATA;
        end else begin
          baud_next = baud_cnt - 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next = RELOAD;
          if (bit_idx == 3'd7) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            bit_next   = bit_idx + 1'b1;
            shift_next = shift >> 1;
            tx_next    = shift[1];
          end
        end else begin
          baud_next = baud_cnt - 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          if (!empty) begin
            // Next byte starts immediately so consecutive frames have no idle gap.
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            baud_next  = RELOAD;
            bit_next   = '0;
            tx_next    = 1'b0;
            state_next = START;
          end else begin
            baud_next  = '0;
            tx_next    = 1'b1;
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_cnt - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values computed above, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      tx       <= tx_next;
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      case ({wr_accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr.wr_en && full && !pop) overflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; pointers and count define validity,
  // so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) mem[wr_ptr] <= wr.wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized and directed bench for uart_tx_fifo against a frame-timer model
// that predicts tx and FIFO status every cycle.
module tb_uart_tx_fifo;

  localparam int CR    = 8;
  localparam int BR    = 1;
  localparam int DL    = 2;
  localparam int DIV   = CR / BR;
  localparam int DEPTH = 1 << DL;
  localparam int FRAME = 10 * DIV;

  logic clk = 1'b0;
  logic rst;
  logic busy, tx;
  logic busy_d, tx_d;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH_LOG2(DL)) bus ();
  uart_tx_fifo_if #(.DEPTH_LOG2(4))  bus_d ();

  uart_tx_fifo #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .DEPTH_LOG2(DL)) u_dut (
    .clk(clk), .rst(rst), .wr(bus), .busy(busy), .tx(tx)
  );

  uart_tx_fifo u_dut_def (
    .clk(clk), .rst(rst), .wr(bus_d), .busy(busy_d), .tx(tx_d)
  );

  int checks = 0;
  int errors = 0;
  int busy_cycles = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a frame is a run of FRAME cycles; a byte is taken from the
  // queue whenever no frame is running after this edge's frame end.
  byte unsigned q[$];
  bit           m_active = 1'b0;
  int           m_phase  = 0;
  logic [7:0]   m_cur    = '0;
  bit           m_ovf    = 1'b0;

  always @(posedge clk) begin
    bit was_full, m_pop, m_acc;
    if (rst) begin
      q.delete();
      m_active = 1'b0;
      m_phase  = 0;
      m_ovf    = 1'b0;
    end else begin
      was_full = (q.size() == DEPTH);
      if (m_active && m_phase == FRAME - 1) m_active = 1'b0;
      else if (m_active)                    m_phase++;
      m_pop = !m_active && (q.size() != 0);
      m_acc = bus.wr_en && (!was_full || m_pop);
      if (bus.wr_en && !m_acc) m_ovf = 1'b1;
      if (m_pop) begin
        m_cur    = q.pop_front();
        m_active = 1'b1;
        m_phase  = 0;
      end
      if (m_acc) q.push_back(bus.wr_data);
    end
  end

  function automatic logic exp_tx();
    int slot;
    if (!m_active) return 1'b1;
    slot = m_phase / DIV;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_cur[slot-1];
  endfunction

  // Drive one cycle of inputs, then compare all outputs after the edge.
  task automatic step(input logic r, input logic we, input logic [7:0] d);
    logic [7:0] exp_v, got_v;
    rst         = r;
    bus.wr_en   = we;
    bus.wr_data = d;
    @(negedge clk);
    exp_v = {exp_tx(), m_active, q.size() == 0, q.size() == DEPTH, m_ovf, 3'(q.size())};
    got_v = {tx, busy, bus.empty, bus.full, bus.overflow, bus.level};
    check("tx_busy_empty_full_ovf_level", 32'(got_v), 32'(exp_v));
    if (busy) busy_cycles++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int burst;
    int low_d;
    int busy_len_d;
    bit r, we;

    rst           = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_data   = '0;
    bus_d.wr_en   = 1'b0;
    bus_d.wr_data = '0;

    // Reset state and single 0x55 frame.
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_level", 32'(bus.level), 32'd0);
    busy_cycles = 0;
    step(1'b0, 1'b1, 8'h55);
    step(1'b0, 1'b0, 8'h00);
    check("latency_tx_low", 32'(tx), 32'd0);
    check("empty_at_pop", 32'(bus.empty), 32'd1);
    idle(100);
    check("busy_len_single", 32'(busy_cycles), 32'd80);

    // Two back-to-back frames.
    busy_cycles = 0;
    step(1'b0, 1'b1, 8'hA3);
    step(1'b0, 1'b1, 8'h0F);
    idle(200);
    check("busy_len_b2b", 32'(busy_cycles), 32'd160);

    // Fill to full, then overflow.
    step(1'b1, 1'b0, 8'h00);
    busy_cycles = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'($urandom));
    check("fill_level", 32'(bus.level), 32'd4);
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_no_ovf", 32'(bus.overflow), 32'd0);
    step(1'b0, 1'b1, 8'hEE);
    check("drop_sets_ovf", 32'(bus.overflow), 32'd1);
    check("drop_level", 32'(bus.level), 32'd4);
    idle(450);
    check("busy_len_five", 32'(busy_cycles), 32'd400);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Write while full on the STOP->START pop edge.
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h10 + i));
    idle(76);
    step(1'b0, 1'b1, 8'hC7);
    check("pop_write_level", 32'(bus.level), 32'd4);
    check("pop_write_no_ovf", 32'(bus.overflow), 32'd0);
    idle(420);

    // Reset during data bit 3 with two bytes queued, write on the same edge.
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(8'h60 + i));
    check("pre_abort_level", 32'(bus.level), 32'd2);
    idle(34);
    step(1'b1, 1'b1, 8'h99);
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_level", 32'(bus.level), 32'd0);
    check("abort_ovf", 32'(bus.overflow), 32'd0);
    busy_cycles = 0;
    idle(200);
    check("abort_no_frames", 32'(busy_cycles), 32'd0);

    // Default-parameter instance: 0xFF frame timing.
    bus_d.wr_en   = 1'b1;
    bus_d.wr_data = 8'hFF;
    step(1'b0, 1'b0, 8'h00);
    bus_d.wr_en = 1'b0;
    low_d       = 0;
    busy_len_d  = 0;
    for (int i = 0; i < 2200; i++) begin
      step(1'b0, 1'b0, 8'h00);
      if (busy_d) busy_len_d++;
      if (!tx_d)  low_d++;
    end
    check("def_frame_len", 32'(busy_len_d), 32'd2080);
    check("def_tx_low_len", 32'(low_d), 32'd208);
    check("def_idle_tx", 32'(tx_d), 32'd1);

    // Randomized traffic with bursts and occasional reset.
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 999) == 0);
      if (burst == 0 && $urandom_range(0, 149) == 0) burst = $urandom_range(3, 8);
      we = (burst > 0) || ($urandom_range(0, 99) < 3);
      if (burst > 0) burst--;
      step(r, we, 8'($urandom));
    end
    idle(500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
